// File: rtl/regbank_sequencer_pkg.sv
// Shared types for the register-bank sequencer: data width default, opcode encodings, FSM states.
// Latency/backpressure are not applicable: declarations only.
package regbank_sequencer_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_LI   = 3'b100,
        OP_MOV  = 3'b101,
        OP_ADDI = 3'b110,
        OP_NOP  = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_A,
        S_READ_B,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    // Two-register-operand ops need the READ_B cycle.
    function automatic logic needs_b(op_t op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    endfunction

endpackage

// File: rtl/alu8.sv
// Combinational datapath for the sequencer: one result plus carry/borrow and zero flags.
// Zero latency, no flow control.
module alu8
    import regbank_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    input  op_t               opcode,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB:  begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_LI:   result = imm;
            OP_MOV:  result = a;
            OP_ADDI: {carry, result} = {1'b0, a} + {1'b0, imm};
            OP_NOP:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/regbank_sequencer.sv
// Multi-cycle sequencer: reads up to two bank registers, runs alu8, writes rd, pulses done.
// ADD/SUB/AND/OR write in cycle 4, done in 5; start is ignored (not queued) while busy.
module regbank_sequencer
    import regbank_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [1:0]        rs_a,
    input  logic [1:0]        rs_b,
    input  logic [1:0]        rd,
    input  logic [DATA_W-1:0] imm,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry,
    output logic              WR,
    output logic [1:0]        rs,
    output logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] regVal
);

    state_t            state;
    op_t               op_q;
    logic [1:0]        rs_b_q;
    logic [1:0]        rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_z;

    alu8 #(.DATA_W(DATA_W)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .imm    (imm_q),
        .opcode (op_q),
        .result (alu_res),
        .carry  (alu_c),
        .zero   (alu_z)
    );

    // Write data is always the last computed result, so it is valid in WRITE and held elsewhere.
    assign data = result;

    // Bus outputs are registered on the transition into the state that uses them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= OP_NOP;
            rs_b_q <= '0;
            rd_q   <= '0;
            imm_q  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            zero   <= 1'b1;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            WR     <= 1'b0;
            rs     <= '0;
        end else begin
            WR   <= 1'b0;
            done <= 1'b0;
            rs   <= '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op_t'(opcode);
                        rs_b_q <= rs_b;
                        rd_q   <= rd;
                        imm_q  <= imm;
                        busy   <= 1'b1;
                        case (op_t'(opcode))
                            OP_LI:   state <= S_EXEC;
                            OP_NOP: begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                            default: begin
                                state <= S_READ_A;
                                rs    <= rs_a;
                            end
                        endcase
                    end
                end
                S_READ_A: begin
                    op_a <= regVal;
                    if (needs_b(op_q)) begin
                        state <= S_READ_B;
                        rs    <= rs_b_q;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_READ_B: begin
                    op_b  <= regVal;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    result <= alu_res;
                    zero   <= alu_z;
                    carry  <= alu_c;
                    WR     <= 1'b1;
                    rs     <= rd_q;
                    state  <= S_WRITE;
                end
                S_WRITE: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/regbank_sequencer.md
REGBANK_SEQUENCER -- requirements
Module: regbank_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register/data width.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request to execute one operation; sampled only in IDLE.
REQ-005 SHALL have port opcode, input, 3: operation select, captured with start.
REQ-006 SHALL have ports rs_a, rs_b, rd, inputs, 2 each: operand A, operand B and destination register indices, captured with start.
REQ-007 SHALL have port imm, input, DATA_W: immediate operand, captured with start.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have ports result (output, DATA_W), zero (output, 1) and carry (output, 1): last computed value and flags, held until the next EXEC.
REQ-011 SHALL have register-bank ports WR (output, 1, write enable), rs (output, 2, register select), data (output, DATA_W, write data), regVal (input, DATA_W, combinational read value of register rs).

Function
REQ-012 SHALL implement states IDLE, READ_A, READ_B, EXEC, WRITE, DONE.
REQ-013 IDLE with start=1 SHALL capture opcode/rs_a/rs_b/rd/imm and go to READ_A; LI goes directly to EXEC; NOP goes directly to DONE.
REQ-014 READ_A SHALL drive rs=rs_a, WR=0 and register regVal as operand A; next state READ_B for ADD/SUB/AND/OR, else EXEC.
REQ-015 READ_B SHALL drive rs=rs_b, WR=0, register regVal as operand B, then go to EXEC.
REQ-016 EXEC SHALL register result and flags, then go to WRITE: 000 ADD A+B, 001 SUB A-B, 010 AND, 011 OR, 100 LI imm, 101 MOV A, 110 ADDI A+imm, 111 NOP (never reaches EXEC).
REQ-017 Arithmetic SHALL wrap modulo 2^DATA_W; carry = carry-out for ADD/ADDI, borrow (A<B) for SUB, 0 otherwise; zero = (result==0).
REQ-018 WRITE SHALL drive rs=rd, data=result, WR=1 for exactly one cycle, then go to DONE.
REQ-019 DONE SHALL assert done for exactly one cycle and return to IDLE; start is not accepted in DONE.
REQ-020 WR SHALL be 0 in every state except WRITE; outside READ_A/READ_B/WRITE rs SHALL hold 0 and data SHALL hold result.
REQ-021 start while busy SHALL be ignored and not queued.
REQ-022 Latency: for ADD/SUB/AND/OR, start sampled at edge 0 SHALL give WR=1 in cycle 4 and done=1 in cycle 5; MOV/ADDI one cycle shorter; LI two cycles shorter; NOP done in cycle 1.
REQ-023 rd equal to rs_a or rs_b SHALL be legal; operands are read before the write.

Reset
REQ-024 rst=1 SHALL force state IDLE, WR=0, rs=0, data=0, result=0, zero=1, carry=0, busy=0, done=0 immediately, independent of clk.
REQ-025 Reset asserted mid-operation SHALL abort it with no write performed and no done pulse.

Structure
REQ-026 A shared package SHALL hold DATA_W default, opcode encodings and the state enumeration.
REQ-027 The datapath SHALL be a combinational sub-module alu8 (operands A, B, imm, opcode -> result, carry, zero), instantiated once.

Verification
REQ-028 Bank preset s0=0x05, s1=0x03; ADD rd=2 rs_a=0 rs_b=1 -> t0=0x08, WR high exactly one cycle (cycle 4), done in cycle 5, zero=0, carry=0.
REQ-029 s0=0xFF, ADDI rs_a=0 imm=0x01 rd=3 -> t1=0x00, zero=1, carry=1; SUB 0x03-0x05 -> 0xFE, carry=1.
REQ-030 LI rd=1 imm=0xA5 -> s1=0xA5, no READ cycles, done in cycle 3; NOP -> WR never asserted, done in cycle 1.
REQ-031 start held high continuously across two operations -> second accepted only on the edge after done, one write per operation.
REQ-032 rst pulsed during READ_B of an ADD -> WR stays 0, no done, outputs at reset values, next start executes normally.
